// File: rtl/rv32_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package rv32_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam int PORT_CPU = 0;
  localparam int PORT_EXT = 1;

  typedef enum logic {
    S_CPU_PRI = 1'b0,
    S_EXT_PRI = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single data-RAM port: CPU has priority, and the
// external requester is lifted to priority after STARVE_LIMIT denied cycles.
//
// state     | meaning
// S_CPU_PRI | CPU wins on conflict (reset state)
// S_EXT_PRI | external port wins its next access, then priority returns to the CPU
module ram_arbiter
  import rv32_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] LIM    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIM_M1 = 4'(STARVE_LIMIT - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic [1:0] w_gnt;
  logic       w_x_denied;
  logic       r_c_rvalid;
  logic       r_x_rvalid;

  // Grants are forced low while reset is asserted so no RAM write can leak out.
  always_comb begin
    w_gnt        = 2'b00;
    w_x_denied   = 1'b0;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;

    if (rst) begin
      case (r_state)
        S_CPU_PRI: begin
          w_gnt[PORT_CPU] = c_req;
          w_gnt[PORT_EXT] = x_req & ~c_req;
        end
        S_EXT_PRI: begin
          w_gnt[PORT_EXT] = x_req;
          w_gnt[PORT_CPU] = c_req & ~x_req;
        end
      endcase
    end

    w_x_denied = x_req & ~w_gnt[PORT_EXT];

    if (!x_req || w_gnt[PORT_EXT]) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt < LIM) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end

    case (r_state)
      S_CPU_PRI: begin
        if (w_x_denied && (r_starve_cnt == LIM_M1)) w_state_nxt = S_EXT_PRI;
      end
      S_EXT_PRI: begin
        if (w_gnt[PORT_EXT] || !x_req) w_state_nxt = S_CPU_PRI;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_CPU_PRI;
      r_starve_cnt <= 4'd0;
      r_c_rvalid   <= 1'b0;
      r_x_rvalid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_c_rvalid   <= w_gnt[PORT_CPU] & ~c_we;
      r_x_rvalid   <= w_gnt[PORT_EXT] & ~x_we;
    end
  end

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_gnt[PORT_CPU]) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (w_gnt[PORT_EXT]) begin
      m_we    = x_we;
      m_addr  = x_addr;
      m_wdata = x_wdata;
    end
  end

  assign c_gnt    = w_gnt[PORT_CPU];
  assign x_gnt    = w_gnt[PORT_EXT];
  assign c_stall  = c_req & ~w_gnt[PORT_CPU];
  assign c_rvalid = r_c_rvalid;
  assign x_rvalid = r_x_rvalid;
  assign c_rdata  = m_rdata;
  assign x_rdata  = m_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run checked
// against a wait-time based priority model and a reference memory.
module tb_ram_arbiter;
  import rv32_pkg::*;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_gnt, c_stall, c_rvalid;
  logic [31:0] c_rdata;
  logic        x_req = 1'b0, x_we = 1'b0;
  logic [31:0] x_addr = '0, x_wdata = '0;
  logic        x_gnt, x_rvalid;
  logic [31:0] x_rdata;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;

  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: data appears the cycle after the address.
  always @(posedge clk) begin
    if (m_we) mem[m_addr[7:2]] <= m_wdata;
    m_rdata <= mem[m_addr[7:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick();
    c_req = 1'b0; x_req = 1'b0; c_we = 1'b0; x_we = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    x_req = 1'b1; x_we = 1'b1; x_addr = 32'h20; x_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      #4;
      n_tests++;
      if ({c_gnt, x_gnt, m_we, c_rvalid, x_rvalid} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: gnt/we/rvalid=%b required 00000", i,
                 {c_gnt, x_gnt, m_we, c_rvalid, x_rvalid});
      end
    end
    tick();
    rst = 1'b1; x_we = 1'b0;
    #4;
    n_tests++;
    if ({c_gnt, x_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: c_gnt,x_gnt=%b required 10", {c_gnt, x_gnt});
    end
    idle();
  endtask

  task automatic test_cpu_read();
    x_req = 1'b1; x_we = 1'b1; x_addr = 32'h10; x_wdata = 32'hDEADBEEF;
    tick();
    x_req = 1'b0; x_we = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    #4;
    n_tests++;
    if ({c_gnt, c_stall, m_addr} !== {2'b10, 32'h10}) begin
      n_fail++;
      $display("FAIL cpu_read_gnt: gnt,stall=%b addr=%h required 10 00000010",
               {c_gnt, c_stall}, m_addr);
    end
    tick();
    c_req = 1'b0;
    #4;
    n_tests++;
    if ({c_rvalid, c_stall, c_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL cpu_read_data: rvalid,stall=%b data=%h required 10 deadbeef",
               {c_rvalid, c_stall}, c_rdata);
    end
    idle();
  endtask

  task automatic test_ext_write();
    x_req = 1'b1; x_we = 1'b1; x_addr = 32'h20; x_wdata = 32'h12345678;
    #4;
    n_tests++;
    if ({x_gnt, m_we, m_addr, m_wdata} !== {2'b11, 32'h20, 32'h12345678}) begin
      n_fail++;
      $display("FAIL ext_write: gnt,we=%b addr=%h data=%h required 11 00000020 12345678",
               {x_gnt, m_we}, m_addr, m_wdata);
    end
    tick();
    x_req = 1'b0; x_we = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
    tick();
    c_req = 1'b0;
    #4;
    n_tests++;
    if ({c_rvalid, c_rdata} !== {1'b1, 32'h12345678}) begin
      n_fail++;
      $display("FAIL ext_write_readback: rvalid=%b data=%h required 1 12345678",
               c_rvalid, c_rdata);
    end
    idle();
  endtask

  task automatic test_starvation();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'h20;
    for (int i = 0; i < LIM; i++) begin
      #4;
      n_tests++;
      if ({c_gnt, x_gnt} !== 2'b10) begin
        n_fail++;
        $display("FAIL starve_deny cyc%0d: c_gnt,x_gnt=%b required 10", i, {c_gnt, x_gnt});
      end
      tick();
    end
    #4;
    n_tests++;
    if ({c_gnt, x_gnt, c_stall, m_addr} !== {3'b011, 32'h20}) begin
      n_fail++;
      $display("FAIL starve_grant: c_gnt,x_gnt,stall=%b addr=%h required 011 00000020",
               {c_gnt, x_gnt, c_stall}, m_addr);
    end
    tick();
    #4;
    n_tests++;
    if ({c_gnt, x_gnt, x_rvalid, x_rdata} !== {3'b101, 32'h12345678} ||
        dut.r_state !== S_CPU_PRI) begin
      n_fail++;
      $display("FAIL starve_after: c_gnt,x_gnt,x_rvalid=%b data=%h state=%0d required 101 12345678 0",
               {c_gnt, x_gnt, x_rvalid}, x_rdata, dut.r_state);
    end
    idle();
  endtask

  task automatic test_withdrawal();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'h20;
    for (int i = 0; i < 2; i++) begin
      #4;
      n_tests++;
      if (x_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL withdraw_deny cyc%0d: x_gnt=%b required 0", i, x_gnt);
      end
      tick();
    end
    x_req = 1'b0;
    tick();
    #4;
    n_tests++;
    if (dut.r_starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL withdraw_clear: starve_cnt=%0d required 0", dut.r_starve_cnt);
    end
    tick();
    x_req = 1'b1;
    for (int i = 0; i <= LIM; i++) begin
      #4;
      n_tests++;
      if (x_gnt !== (i == LIM)) begin
        n_fail++;
        $display("FAIL withdraw_rerequest cyc%0d: x_gnt=%b required %b", i, x_gnt, i == LIM);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    #4;
    n_tests++;
    if (c_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_gnt: c_gnt=%b required 1", c_gnt);
    end
    rst = 1'b0;
    tick();
    c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hCAFEF00D;
    x_req = 1'b1; x_we = 1'b1; x_addr = 32'h30; x_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      #4;
      n_tests++;
      if ({c_rvalid, c_gnt, x_gnt, m_we} !== 4'b0 || dut.r_state !== S_CPU_PRI) begin
        n_fail++;
        $display("FAIL midreset_hold cyc%0d: rvalid,gnts,we=%b state=%0d required 0000 0",
                 i, {c_rvalid, c_gnt, x_gnt, m_we}, dut.r_state);
      end
      tick();
    end
    n_tests++;
    if (mem[12] !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_nowrite: mem[0x30]=%h required 00000000", mem[12]);
    end
    rst = 1'b1;
    c_req = 1'b0; x_req = 1'b0; c_we = 1'b0; x_we = 1'b0;
    idle();
  endtask

  // Priority model: the external port wins once it has waited LIM cycles in a row.
  task automatic test_random();
    int          x_wait  = 0;
    bit          ec, ex;
    bit          exp_crv = 1'b0, exp_xrv = 1'b0;
    logic [31:0] exp_crd = '0, exp_xrd = '0;
    logic [64:0] exp_bus;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!c_req && $urandom_range(0, 9) < 6) begin
        c_req = 1'b1; c_we = ($urandom_range(0, 2) == 0);
        c_addr = 32'($urandom_range(0, 63)) << 2; c_wdata = $urandom;
      end
      if (!x_req) begin
        if ($urandom_range(0, 9) < 5) begin
          x_req = 1'b1; x_we = ($urandom_range(0, 2) == 0);
          x_addr = 32'($urandom_range(0, 63)) << 2; x_wdata = $urandom;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        x_req = 1'b0;
      end
      ex = x_req && (!c_req || x_wait >= LIM);
      ec = c_req && !ex;
      exp_bus = ec ? {c_we, c_addr, c_wdata} : ex ? {x_we, x_addr, x_wdata} : 65'b0;
      #4;
      n_tests++;
      if ({c_gnt, x_gnt, c_stall} !== {ec, ex, c_req && !ec}) begin
        n_fail++;
        $display("FAIL rand_gnt cyc%0d: c_gnt,x_gnt,stall=%b required %b", cyc,
                 {c_gnt, x_gnt, c_stall}, {ec, ex, c_req && !ec});
      end
      n_tests++;
      if ({m_we, m_addr, m_wdata} !== exp_bus) begin
        n_fail++;
        $display("FAIL rand_bus cyc%0d: we/addr/data=%h required %h", cyc,
                 {m_we, m_addr, m_wdata}, exp_bus);
      end
      n_tests++;
      if ({c_rvalid, x_rvalid} !== {exp_crv, exp_xrv}) begin
        n_fail++;
        $display("FAIL rand_rvalid cyc%0d: c,x=%b required %b", cyc,
                 {c_rvalid, x_rvalid}, {exp_crv, exp_xrv});
      end
      if (exp_crv) begin
        n_tests++;
        if (c_rdata !== exp_crd) begin
          n_fail++;
          $display("FAIL rand_crdata cyc%0d: %h required %h", cyc, c_rdata, exp_crd);
        end
      end
      if (exp_xrv) begin
        n_tests++;
        if (x_rdata !== exp_xrd) begin
          n_fail++;
          $display("FAIL rand_xrdata cyc%0d: %h required %h", cyc, x_rdata, exp_xrd);
        end
      end
      exp_crv = ec && !c_we;
      exp_xrv = ex && !x_we;
      if (ec) begin
        if (c_we) ref_mem[c_addr[7:2]] = c_wdata;
        else exp_crd = ref_mem[c_addr[7:2]];
      end
      if (ex) begin
        if (x_we) ref_mem[x_addr[7:2]] = x_wdata;
        else exp_xrd = ref_mem[x_addr[7:2]];
      end
      if (x_req && !ex) x_wait++;
      else x_wait = 0;
      tick();
      if (ec) c_req = 1'b0;
      if (ex) x_req = 1'b0;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_starvation();
    test_withdrawal();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single data-RAM port between the CPU memory-access stage and one external requester (program loader / debug port). CPU accesses have priority. The external port is guaranteed service through a starvation counter. Sits between the `cpu` data-memory outputs (`ram_addr`, `ram_we`, `ram_wdata`, `ram_rdata`) and the synchronous-read RAM. It drives a stall back to the pipeline whenever a CPU request is not granted.

## Interface
- `ADDR_W`, 32, address width of both ports and the RAM
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive denied external cycles before the external port gets priority (legal range 1..15)

- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-low (0 = reset), sampled on rising `clk`
- `c_req`  in  1  CPU access request, valid this cycle
- `c_we`  in  1  CPU write enable (1 = write, 0 = read)
- `c_addr`  in  ADDR_W  CPU address
- `c_wdata`  in  DATA_W  CPU write data
- `c_gnt`  out  1  CPU access issued to RAM this cycle
- `c_stall`  out  1  `c_req & ~c_gnt`; pipeline must hold its request
- `c_rvalid`  out  1  CPU read data valid (cycle after a granted read)
- `c_rdata`  out  DATA_W  CPU read data
- `x_req`, `x_we`, `x_addr`, `x_wdata`  in  1/1/ADDR_W/DATA_W  external request, same meaning as the CPU signals
- `x_gnt`, `x_rvalid`  out  1  external grant / read valid
- `x_rdata`  out  DATA_W  external read data
- `m_we`  out  1  RAM write enable
- `m_addr`  out  ADDR_W  RAM address
- `m_wdata`  out  DATA_W  RAM write data
- `m_rdata`  in  DATA_W  RAM read data, valid 1 cycle after the address is presented

## Operation
- FSM states: `S_CPU_PRI` (reset state) and `S_EXT_PRI`.
- Grant (combinational from state and requests):
  - In `S_CPU_PRI`: `c_gnt = c_req`; `x_gnt = x_req & ~c_req`.
  - In `S_EXT_PRI`: `x_gnt = x_req`; `c_gnt = c_req & ~x_req`.
  - At most one grant per cycle. While `rst` = 0, both grants are 0.
- RAM mux: the granted port's `we`/`addr`/`wdata` drive `m_*`. With no grant, `m_we` = 0, `m_addr` = 0 and `m_wdata` = 0.
- Starvation counter `starve_cnt` (4 bits):
  - +1 on each cycle with `x_req & ~x_gnt`.
  - Cleared on `x_gnt`, or on `~x_req`.
  - Saturates at `STARVE_LIMIT`.
- Transitions:
  - `S_CPU_PRI` → `S_EXT_PRI` when `x_req & ~x_gnt` and `starve_cnt == STARVE_LIMIT-1`.
  - `S_EXT_PRI` → `S_CPU_PRI` on `x_gnt` (exactly one external access is taken at elevated priority).
  - `S_EXT_PRI` → `S_CPU_PRI` if `x_req` drops, with the counter cleared.
- Requesters hold `req`, `addr`, `we` and `wdata` stable until granted. The CPU does this through `c_stall`.
- Read return:
  - `c_rvalid` <= `c_gnt & ~c_we`; `x_rvalid` <= `x_gnt & ~x_we`.
  - `c_rdata` = `m_rdata` and `x_rdata` = `m_rdata` (wired). Data is meaningful only when the matching `rvalid` = 1.
- Writes return no response. A write is complete at the grant edge.

## Timing
- Reset values (on the edge with `rst` = 0):
  - state = `S_CPU_PRI`, `starve_cnt` = 0, `c_rvalid` = 0, `x_rvalid` = 0.
  - Combinational outputs `c_gnt`, `x_gnt`, `m_we` are held at 0 while `rst` = 0.
- Grant latency:
  - 0 cycles for the priority owner.
  - Worst-case external wait under continuous CPU traffic is `STARVE_LIMIT` cycles. The grant comes on cycle `STARVE_LIMIT+1` of asserting `x_req`.
- Read latency: 1 cycle from grant to `rvalid`. Back-to-back reads from either or alternating ports sustain 1 access/cycle.
- Simultaneous requests: resolved by the current state as above. The loser's `req` and payload must be held.
- Reset mid-operation: a read granted in the cycle before reset yields no `rvalid`. The FSM returns to `S_CPU_PRI` and no RAM write is issued while `rst` = 0.
- `c_stall` is combinational and has no registered path into the CPU stall logic.

## Structure
- Shared package `rv32_pkg` holds:
  - `arb_state_t` (`S_CPU_PRI`, `S_EXT_PRI`)
  - `ADDR_W`/`DATA_W` defaults
  - the port index constants `PORT_CPU` = 0 and `PORT_EXT` = 1
- Single module, no sub-modules. The counter and FSM are small enough to inline (target ~150 lines).

## Test plan
- Reset: hold `rst` = 0 with both reqs high for 3 cycles → `c_gnt` = `x_gnt` = `m_we` = 0 and `rvalid` = 0. Release → `c_gnt` = 1 on the first cycle.
- CPU read: `c_req` = 1, `c_we` = 0, `c_addr` = 0x10, RAM holds 0xDEADBEEF → `c_gnt` same cycle, `c_rvalid` = 1 and `c_rdata` = 0xDEADBEEF the next cycle, `c_stall` = 0 throughout.
- External write when idle: `x_req` = 1, `x_we` = 1, `x_addr` = 0x20, `x_wdata` = 0x12345678, `c_req` = 0 → `x_gnt` = 1, `m_we` = 1, `m_addr` = 0x20. A later CPU read of 0x20 returns 0x12345678.
- Starvation (`STARVE_LIMIT` = 4): `c_req` held high and `x_req` raised at cycle 0 →
  - cycles 0–3: `c_gnt` = 1 and `x_gnt` = 0;
  - cycle 4: `x_gnt` = 1, `c_gnt` = 0, `c_stall` = 1;
  - cycle 5: `c_gnt` = 1 and state = `S_CPU_PRI`.
- Withdrawal: after 2 denied cycles, drop `x_req` → `starve_cnt` = 0. Re-raise `x_req` → another 4 denied cycles before the grant.
- Reset mid-read: CPU read granted, then `rst` = 0 on the next edge → no `c_rvalid` pulse and state = `S_CPU_PRI`.
